// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU data-memory path: access size and LSU FSM states.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_W = 8);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_to_write;
    logic              mem_write_enable;
    logic [31:0]       mem_memory_output;

    // slave: the LSU itself; master: the CPU plus the data memory around it
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_memory_output,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_address, mem_data_to_write, mem_write_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_memory_output,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_address, mem_data_to_write, mem_write_enable
    );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational load extract/extend and byte/half store merge (little-endian, low lanes).
module lsu_data_align
    import cpu_mem_pkg::*;
(
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_rd_word[7];
    assign w_sign_h = ~i_unsigned & i_rd_word[15];

    always_comb begin
        o_load_data  = i_rd_word;
        o_store_word = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data  = {{24{w_sign_b}}, i_rd_word[7:0]};
                o_store_word = {i_rd_word[31:8], i_wdata[7:0]};
            end
            SZ_HALF: begin
                o_load_data  = {{16{w_sign_h}}, i_rd_word[15:0]};
                o_store_word = {i_rd_word[31:16], i_wdata[15:0]};
            end
            default: begin
                o_load_data  = i_rd_word;
                o_store_word = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time; sub-word stores are read-modify-write.
module load_store_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_next;
    logic              r_write;
    logic              r_unsigned;
    logic              r_err;
    size_e             r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rd_word;
    logic              w_accept;
    logic [31:0]       w_load_data;
    logic [31:0]       w_store_word;
    logic              w_in_resp;

    assign bus.req_ready = (r_state == IDLE) && !reset;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_in_resp     = (r_state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (size_e'(bus.req_size) == SZ_ILL) begin
                        w_state_next = RESP;
                    end else if (bus.req_write && size_e'(bus.req_size) == SZ_WORD) begin
                        w_state_next = WR;
                    end else begin
                        w_state_next = RD;
                    end
                end
            end
            RD:      w_state_next = CAP;
            CAP:     w_state_next = r_write ? WR : RESP;
            WR:      w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_word  <= '0;
        end else if (w_accept) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_err      <= (size_e'(bus.req_size) == SZ_ILL);
            r_size     <= size_e'(bus.req_size);
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
        end else if (r_state == CAP) begin
            r_rd_word  <= bus.mem_memory_output;
        end
    end

    lsu_data_align u_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_rd_word    (r_rd_word),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // Outputs decode from async-reset state, so reset clears them without a clock
    assign bus.mem_write_enable  = (r_state == WR);
    assign bus.mem_address       = r_addr;
    assign bus.mem_data_to_write = w_store_word;
    assign bus.rsp_valid         = w_in_resp;
    assign bus.rsp_error         = w_in_resp && r_err;
    assign bus.rsp_rdata         = (w_in_resp && !r_write && !r_err) ? w_load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed registered-read memory model.
module tb_load_store_unit;

    logic clk;
    logic reset;

    load_store_unit_if #(.ADDR_W(8)) bus ();

    load_store_unit #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            mem[bus.mem_address]        <= bus.mem_data_to_write[7:0];
            mem[bus.mem_address + 8'd1] <= bus.mem_data_to_write[15:8];
            mem[bus.mem_address + 8'd2] <= bus.mem_data_to_write[23:16];
            mem[bus.mem_address + 8'd3] <= bus.mem_data_to_write[31:24];
        end
        bus.mem_memory_output <= {mem[bus.mem_address + 8'd3], mem[bus.mem_address + 8'd2],
                                  mem[bus.mem_address + 8'd1], mem[bus.mem_address]};
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we_at;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_valid    = 1'b1;
        bus.req_write    = v.wr;
        bus.req_size     = v.sz;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
    endtask

    // Issue one request and watch up to 8 cycles; cycle k=1 is the cycle after the accept edge
    task automatic run_op(input vec_t v, input string name, output int lat,
                          output logic [31:0] rd, output logic er,
                          output int we_n, output int we_at);
        lat = 0; rd = 32'h0; er = 1'b0; we_n = 0; we_at = 0;
        @(negedge clk);
        drive_req(v);
        chk({name, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_write_enable) begin
                we_n++;
                we_at = k;
            end
            if (bus.rsp_valid) begin
                lat = k;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_error;
                break;
            end
        end
    endtask

    vec_t vecs [22];

    initial begin
        int          lat, we_n, we_at, rsp_n, rdy_bad;
        logic [31:0] rd;
        logic        er;
        vec_t        v;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 8'h00, 32'h00000000, 32'h0, 1'b0, 2, 1};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344, 32'h0, 1'b0, 2, 1};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 8'h30, 32'h0000F080, 32'h0, 1'b0, 2, 1};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 8'h40, 32'h01020304, 32'h0, 1'b0, 2, 1};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 8'h20, 32'h5A5A5AAA, 32'h0, 1'b0, 4, 3};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 8'h20, 32'h0,        32'h112233AA, 1'b0, 3, 0};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 8'h30, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 8'h30, 32'h0,        32'h0000F080, 1'b0, 3, 0};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 8'h30, 32'h0,        32'h00000080, 1'b0, 3, 0};
        vecs[11] = '{1'b0, 2'b01, 1'b0, 8'h30, 32'h0,        32'hFFFFF080, 1'b0, 3, 0};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 8'h10, 32'h12345678, 32'h0, 1'b1, 1, 0};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        32'h0, 1'b1, 1, 0};
        vecs[14] = '{1'b1, 2'b01, 1'b0, 8'h40, 32'hCAFEBABE, 32'h0, 1'b0, 4, 3};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 8'h40, 32'h0,        32'h0102BABE, 1'b0, 3, 0};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 8'hFE, 32'hA1B2C3D4, 32'h0, 1'b0, 2, 1};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 8'h00, 32'h0,        32'h0000A1B2, 1'b0, 3, 0};
        vecs[18] = '{1'b0, 2'b10, 1'b0, 8'hFE, 32'h0,        32'hA1B2C3D4, 1'b0, 3, 0};
        vecs[19] = '{1'b0, 2'b10, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
        vecs[20] = '{1'b1, 2'b10, 1'b0, 8'h50, 32'h55555555, 32'h0, 1'b0, 2, 1};
        vecs[21] = '{1'b0, 2'b00, 1'b0, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 3, 0};

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 8'h00;
        bus.req_wdata    = 32'h0;
        reset = 1'b1;

        // Reset state, checked before the first clock edge
        #2;
        chk("rst_ready", {31'h0, bus.req_ready},        32'h0);
        chk("rst_valid", {31'h0, bus.rsp_valid},        32'h0);
        chk("rst_error", {31'h0, bus.rsp_error},        32'h0);
        chk("rst_rdata", bus.rsp_rdata,                 32'h0);
        chk("rst_we",    {31'h0, bus.mem_write_enable}, 32'h0);
        chk("rst_addr",  {24'h0, bus.mem_address},      32'h0);
        chk("rst_wdata", bus.mem_data_to_write,         32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i), lat, rd, er, we_n, we_at);
            $display("txn %0d: wr=%0b sz=%0b uns=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b we_n=%0d we_at=%0d",
                     i, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                     lat, rd, er, we_n, we_at);
            chk($sformatf("v%0d_lat", i),   lat,          vecs[i].exp_lat);
            chk($sformatf("v%0d_rdata", i), rd,           vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i),   {31'h0, er},  {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_we_n", i),  we_n,         (vecs[i].exp_we_at != 0) ? 1 : 0);
            chk($sformatf("v%0d_we_at", i), we_at,        vecs[i].exp_we_at);
        end

        // req_valid held through a load; the second request must wait for IDLE
        rsp_n = 0; rdy_bad = 0;
        @(negedge clk);
        v = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 0, 0};
        drive_req(v);
        chk("bp_ready0", {31'h0, bus.req_ready}, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2 || k == 3 || k == 5 || k == 6 || k == 7) begin
                if (bus.req_ready) rdy_bad++;
            end
            if (bus.rsp_valid) begin
                rsp_n++;
                if (k == 3) chk("bp_rsp1_data", bus.rsp_rdata, 32'hDEADBEEF);
                else if (k == 7) chk("bp_rsp2_data", bus.rsp_rdata, 32'h112233AA);
                else chk("bp_rsp_cycle", k, 0);
            end
            if (k == 3) begin
                v.addr = 8'h20;
                drive_req(v);
            end
            if (k == 4) begin
                chk("bp_ready_idle", {31'h0, bus.req_ready}, 32'h1);
                @(posedge clk);
                #1 bus.req_valid = 1'b0;
            end
        end
        $display("txn backpressure: responses=%0d busy_ready_violations=%0d", rsp_n, rdy_bad);
        chk("bp_rsp_count", rsp_n, 2);
        chk("bp_busy_ready", rdy_bad, 0);

        // Reset asserted between clock edges while in WR
        @(negedge clk);
        v = '{1'b1, 2'b10, 1'b0, 8'h50, 32'h12345678, 32'h0, 1'b0, 0, 0};
        drive_req(v);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mr_we_before", {31'h0, bus.mem_write_enable}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("mr_we_after",  {31'h0, bus.mem_write_enable}, 32'h0);
        chk("mr_ready_rst", {31'h0, bus.req_ready},        32'h0);
        chk("mr_valid_rst", {31'h0, bus.rsp_valid},        32'h0);
        chk("mr_addr_rst",  {24'h0, bus.mem_address},      32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mr_ready_release", {31'h0, bus.req_ready}, 32'h1);
        rsp_n = 0; we_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_n++;
            if (bus.mem_write_enable) we_n++;
        end
        $display("txn midreset: responses=%0d writes=%0d", rsp_n, we_n);
        chk("mr_no_rsp", rsp_n, 0);
        chk("mr_no_we",  we_n,  0);

        v = '{1'b0, 2'b10, 1'b0, 8'h50, 32'h0, 32'h0, 1'b0, 0, 0};
        run_op(v, "mr_load", lat, rd, er, we_n, we_at);
        $display("txn midreset_readback: addr=50 -> lat=%0d rdata=%h", lat, rd);
        chk("mr_mem_kept", rd, 32'h55555555);
        chk("mr_load_lat", lat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
